// File: rtl/wb_pkg.sv
// Shared types for the RV64 writeback stage: data width, load funct3 encodings
// and the writeback request record used to carry the arbitration winner.
package wb_pkg;

   localparam int XLEN = 64;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LD  = 3'b011,
      LBU = 3'b100,
      LHU = 3'b101,
      LWU = 3'b110
   } ld_funct3_e;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load lane extraction: shifts the returned doubleword down to the
// addressed byte and sign/zero extends it according to the load funct3.
module load_align
   import wb_pkg::*;
(
   input  logic [63:0] data,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] result,
   output logic        illegal
);

   logic [63:0] shifted;

   // Bytes shifted in from above bit 63 are zero, so misaligned accesses simply lose their upper lanes.
   always_comb begin
      shifted = data >> {offset, 3'b000};
      result  = '0;
      illegal = 1'b0;
      case (ld_funct3_e'(funct3))
         LB:      result = {{56{shifted[7]}},  shifted[7:0]};
         LH:      result = {{48{shifted[15]}}, shifted[15:0]};
         LW:      result = {{32{shifted[31]}}, shifted[31:0]};
         LD:      result = shifted;
         LBU:     result = {56'd0, shifted[7:0]};
         LHU:     result = {48'd0, shifted[15:0]};
         LWU:     result = {32'd0, shifted[31:0]};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// RV64 writeback stage: load/ALU arbitration onto one registered register-file
// write port, pending-load scoreboard and outstanding-load counter.
// Optional WB_BYPASS_EN adds a two-port combinational bypass from the writeback slot.
module wb_stage #(
   parameter int XLEN   = 64,
   parameter int MAX_LD = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_issue_valid,
   output logic            ld_issue_ready,
   input  logic [4:0]      ld_issue_rd,
   input  logic            ld_resp_valid,
   input  logic [4:0]      ld_resp_rd,
   input  logic [63:0]     ld_resp_data,
   input  logic [2:0]      ld_resp_funct3,
   input  logic [2:0]      ld_resp_offset,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_en,
   output logic [31:0]     pending,
`ifdef WB_BYPASS_EN
   input  logic [4:0]      byp_addr1,
   input  logic [4:0]      byp_addr2,
   output logic            byp_hit1,
   output logic            byp_hit2,
   output logic [XLEN-1:0] byp_data1,
   output logic [XLEN-1:0] byp_data2,
`endif
   output logic            ld_err
);

   import wb_pkg::wb_req_t;

   localparam int CW = $clog2(MAX_LD) + 1;

   logic [CW-1:0] ld_count;
   logic          count_zero;
   logic          issue_acc;
   logic          resp_acc;
   logic [63:0]   ld_result;
   logic          ld_illegal;
   wb_req_t       winner;
   logic [31:0]   pend_set;
   logic [31:0]   pend_clr;

   load_align u_load_align (
      .data    (ld_resp_data),
      .offset  (ld_resp_offset),
      .funct3  (ld_resp_funct3),
      .result  (ld_result),
      .illegal (ld_illegal)
   );

   assign count_zero     = (ld_count == '0);
   assign alu_ready      = !reset && !ld_resp_valid;
   assign ld_issue_ready = !reset && (ld_count != CW'(MAX_LD));
   assign issue_acc      = ld_issue_valid && ld_issue_ready;
   // A response with nothing outstanding is a protocol error and is dropped, yet it still blocks the ALU.
   assign resp_acc       = ld_resp_valid && !count_zero;

   always_comb begin
      winner = '0;
      if (resp_acc) begin
         winner.valid = 1'b1;
         winner.rd    = ld_resp_rd;
         winner.data  = ld_result;
      end else if (alu_valid && alu_ready) begin
         winner.valid = 1'b1;
         winner.rd    = alu_rd;
         winner.data  = alu_data;
      end
   end

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (issue_acc && ld_issue_rd != 5'd0)
         pend_set[ld_issue_rd] = 1'b1;
      if (resp_acc)
         pend_clr[ld_resp_rd] = 1'b1;
   end

   // Clearing before setting makes a same-cycle issue win over a response to the same register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         pending  <= '0;
         ld_count <= '0;
         ld_err   <= 1'b0;
      end else begin
         if (winner.valid) begin
            wb_en   <= (winner.rd != 5'd0);
            wb_addr <= winner.rd;
            wb_data <= winner.data;
         end else begin
            wb_en <= 1'b0;
         end
         pending <= ((pending & ~pend_clr) | pend_set) & ~32'd1;
         if (issue_acc && !resp_acc)
            ld_count <= ld_count + 1'b1;
         else if (!issue_acc && resp_acc)
            ld_count <= ld_count - 1'b1;
         if (ld_resp_valid && (count_zero || ld_illegal))
            ld_err <= 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_hit1  = wb_en && (wb_addr == byp_addr1) && (byp_addr1 != 5'd0);
   assign byp_hit2  = wb_en && (wb_addr == byp_addr2) && (byp_addr2 != 5'd0);
   assign byp_data1 = wb_data;
   assign byp_data2 = wb_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios pinned to literal values
// plus randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

   localparam int XLEN   = 64;
   localparam int MAX_LD = 8;

   logic            clk;
   logic            reset;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_issue_valid;
   logic            ld_issue_ready;
   logic [4:0]      ld_issue_rd;
   logic            ld_resp_valid;
   logic [4:0]      ld_resp_rd;
   logic [63:0]     ld_resp_data;
   logic [2:0]      ld_resp_funct3;
   logic [2:0]      ld_resp_offset;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            wb_en;
   logic [31:0]     pending;
   logic            ld_err;
   logic [4:0]      byp_addr1;
   logic [4:0]      byp_addr2;
`ifdef WB_BYPASS_EN
   logic            byp_hit1;
   logic            byp_hit2;
   logic [XLEN-1:0] byp_data1;
   logic [XLEN-1:0] byp_data2;
`endif

   wb_stage #(.XLEN(XLEN), .MAX_LD(MAX_LD)) dut (
      .clk            (clk),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_issue_valid (ld_issue_valid),
      .ld_issue_ready (ld_issue_ready),
      .ld_issue_rd    (ld_issue_rd),
      .ld_resp_valid  (ld_resp_valid),
      .ld_resp_rd     (ld_resp_rd),
      .ld_resp_data   (ld_resp_data),
      .ld_resp_funct3 (ld_resp_funct3),
      .ld_resp_offset (ld_resp_offset),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .wb_en          (wb_en),
      .pending        (pending),
`ifdef WB_BYPASS_EN
      .byp_addr1      (byp_addr1),
      .byp_addr2      (byp_addr2),
      .byp_hit1       (byp_hit1),
      .byp_hit2       (byp_hit2),
      .byp_data1      (byp_data1),
      .byp_data2      (byp_data2),
`endif
      .ld_err         (ld_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;
   bit last_alu_ready;
   bit last_issue_ready;

   // Behavioural model state, advanced once per clock edge from the driven inputs.
   bit          m_en;
   logic [4:0]  m_addr;
   logic [63:0] m_data;
   logic [31:0] m_pend;
   int          m_count;
   bit          m_err;
   int          outq[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected load value built byte by byte from the returned doubleword.
   function automatic logic [63:0] expectLoad(input logic [63:0] d, input int off, input int f3);
      logic [63:0] v = '0;
      int nbytes;
      if (f3 == 7) return '0;
      nbytes = 1 << (f3 % 4);
      for (int k = 0; k < nbytes; k++)
         if (off + k < 8)
            v = v | (64'(d[(off + k) * 8 +: 8]) << (8 * k));
      if (f3 < 4 && nbytes < 8 && v[8 * nbytes - 1])
         v = v | (~64'd0 << (8 * nbytes));
      return v;
   endfunction

   task automatic modelStep();
      bit ia;
      bit ra;
      logic [31:0] np;
      if (reset) begin
         m_en = 0; m_addr = '0; m_data = '0; m_pend = '0; m_count = 0; m_err = 0;
         outq.delete();
         return;
      end
      ia = ld_issue_valid && (m_count != MAX_LD);
      ra = ld_resp_valid && (m_count != 0);
      if (ld_resp_valid && (m_count == 0 || ld_resp_funct3 == 3'd7)) m_err = 1;
      if (ra) begin
         m_en   = (ld_resp_rd != 0);
         m_addr = ld_resp_rd;
         m_data = expectLoad(ld_resp_data, int'(ld_resp_offset), int'(ld_resp_funct3));
      end else if (!ld_resp_valid && alu_valid) begin
         m_en   = (alu_rd != 0);
         m_addr = alu_rd;
         m_data = alu_data;
      end else begin
         m_en = 0;
      end
      np = m_pend;
      if (ra) np[ld_resp_rd] = 1'b0;
      if (ia && ld_issue_rd != 0) np[ld_issue_rd] = 1'b1;
      np[0] = 1'b0;
      m_pend = np;
      m_count = m_count + int'(ia) - int'(ra);
      if (ia) outq.push_back(int'(ld_issue_rd));
   endtask

   // Drives one cycle with the currently set inputs, then returns the valids to idle.
   task automatic applyStimulus();
      #1;
      last_alu_ready   = alu_ready;
      last_issue_ready = ld_issue_ready;
      @(posedge clk);
      modelStep();
      #1;
      alu_valid      = 1'b0;
      ld_issue_valid = 1'b0;
      ld_resp_valid  = 1'b0;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
   endtask

   task automatic setResp(input logic [4:0] rd, input logic [63:0] d, input logic [2:0] f3, input logic [2:0] off);
      ld_resp_valid  = 1'b1;
      ld_resp_rd     = rd;
      ld_resp_data   = d;
      ld_resp_funct3 = f3;
      ld_resp_offset = off;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("alu_ready", 64'(alu_ready), 64'(!reset && !ld_resp_valid));
         checkOutput("ld_issue_ready", 64'(ld_issue_ready), 64'(!reset && m_count != MAX_LD));
         checkOutput("wb_en", 64'(wb_en), 64'(m_en));
         checkOutput("wb_addr", 64'(wb_addr), 64'(m_addr));
         checkOutput("wb_data", wb_data, m_data);
         checkOutput("pending", 64'(pending), 64'(m_pend));
         checkOutput("ld_err", 64'(ld_err), 64'(m_err));
`ifdef WB_BYPASS_EN
         checkOutput("byp_hit1", 64'(byp_hit1), 64'(m_en && m_addr == byp_addr1 && byp_addr1 != 0));
         checkOutput("byp_hit2", 64'(byp_hit2), 64'(m_en && m_addr == byp_addr2 && byp_addr2 != 0));
         checkOutput("byp_data1", byp_data1, m_data);
         checkOutput("byp_data2", byp_data2, m_data);
`endif
      end
   end

   initial begin
      reset = 1'b1; alu_valid = 0; alu_rd = '0; alu_data = '0;
      ld_issue_valid = 0; ld_issue_rd = '0; ld_resp_valid = 0; ld_resp_rd = '0;
      ld_resp_data = '0; ld_resp_funct3 = '0; ld_resp_offset = '0;
      byp_addr1 = '0; byp_addr2 = '0;

      // Reset state, with requests offered so the ready gating is exercised.
      alu_valid = 1'b1; ld_issue_valid = 1'b1;
      applyStimulus();
      check_en = 1'b1;
      alu_valid = 1'b1; ld_issue_valid = 1'b1;
      applyStimulus();
      checkOutput("rst_alu_ready", 64'(last_alu_ready), 64'd0);
      checkOutput("rst_issue_ready", 64'(last_issue_ready), 64'd0);
      checkOutput("rst_wb_en", 64'(wb_en), 64'd0);
      checkOutput("rst_wb_data", wb_data, 64'd0);
      checkOutput("rst_pending", 64'(pending), 64'd0);
      reset = 1'b0;

      // ALU only.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      applyStimulus();
      checkOutput("alu_only_ready", 64'(last_alu_ready), 64'd1);
      checkOutput("alu_only_en", 64'(wb_en), 64'd1);
      checkOutput("alu_only_addr", 64'(wb_addr), 64'd5);
      checkOutput("alu_only_data", wb_data, 64'h1234);

      // Collision: load wins, ALU follows a cycle later.
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
      applyStimulus();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hAAAA;
      setResp(5'd4, 64'h0123_4567_89AB_CDEF, 3'd3, 3'd0);
      applyStimulus();
      checkOutput("coll_alu_ready", 64'(last_alu_ready), 64'd0);
      checkOutput("coll_ld_addr", 64'(wb_addr), 64'd4);
      checkOutput("coll_ld_data", wb_data, 64'h0123_4567_89AB_CDEF);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hAAAA;
      applyStimulus();
      checkOutput("coll_alu_ready2", 64'(last_alu_ready), 64'd1);
      checkOutput("coll_alu_addr", 64'(wb_addr), 64'd3);
      checkOutput("coll_alu_data", wb_data, 64'hAAAA);

      // Extension: LH and LHU at byte offset 6.
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
      applyStimulus();
      setResp(5'd10, 64'h80FF_0000_0000_0000, 3'd1, 3'd6);
      applyStimulus();
      checkOutput("ext_lh", wb_data, 64'hFFFF_FFFF_FFFF_80FF);
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
      applyStimulus();
      setResp(5'd10, 64'h80FF_0000_0000_0000, 3'd5, 3'd6);
      applyStimulus();
      checkOutput("ext_lhu", wb_data, 64'h80FF);

      // Scoreboard: pending[7] high for exactly two cycles; rd 0 never marks or writes.
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
      applyStimulus();
      checkOutput("sb_pend7_a", 64'(pending[7]), 64'd1);
      applyStimulus();
      checkOutput("sb_pend7_b", 64'(pending[7]), 64'd1);
      setResp(5'd7, 64'h77, 3'd3, 3'd0);
      applyStimulus();
      checkOutput("sb_pend7_c", 64'(pending[7]), 64'd0);
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
      applyStimulus();
      checkOutput("sb_rd0_pend", 64'(pending), 64'd0);
      setResp(5'd0, 64'h55, 3'd3, 3'd0);
      applyStimulus();
      checkOutput("sb_rd0_wb_en", 64'(wb_en), 64'd0);

      // Counter saturation, recovery, then a response with nothing outstanding.
      for (int i = 0; i < MAX_LD; i++) begin
         ld_issue_valid = 1'b1; ld_issue_rd = 5'(11 + i);
         applyStimulus();
      end
      checkOutput("sat_ready_low", 64'(ld_issue_ready), 64'd0);
      setResp(5'd11, 64'h11, 3'd3, 3'd0);
      applyStimulus();
      checkOutput("sat_ready_back", 64'(ld_issue_ready), 64'd1);
      for (int i = 1; i < MAX_LD; i++) begin
         setResp(5'(11 + i), 64'(i), 3'd3, 3'd0);
         applyStimulus();
      end
      checkOutput("sat_err_before", 64'(ld_err), 64'd0);
      setResp(5'd20, 64'hDEAD, 3'd3, 3'd0);
      applyStimulus();
      checkOutput("zero_cnt_err", 64'(ld_err), 64'd1);
      checkOutput("zero_cnt_no_wr", 64'(wb_en), 64'd0);

      // Illegal funct3 writes zero and flags an error.
      resetDut();
      checkOutput("err_cleared", 64'(ld_err), 64'd0);
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd21;
      applyStimulus();
      setResp(5'd21, ~64'd0, 3'd7, 3'd0);
      applyStimulus();
      checkOutput("ill_wb_en", 64'(wb_en), 64'd1);
      checkOutput("ill_wb_data", wb_data, 64'd0);
      checkOutput("ill_err", 64'(ld_err), 64'd1);

`ifdef WB_BYPASS_EN
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
      byp_addr1 = 5'd9; byp_addr2 = 5'd0;
      applyStimulus();
      checkOutput("byp_hit1_lit", 64'(byp_hit1), 64'd1);
      checkOutput("byp_data1_lit", byp_data1, 64'h99);
      checkOutput("byp_hit2_lit", 64'(byp_hit2), 64'd0);
`endif

      // Randomized traffic: responses follow accepted issues in order, occasional mid-run reset.
      resetDut();
      for (int c = 0; c < 3000; c++) begin
         reset          = ($urandom_range(0, 299) == 0);
         alu_valid      = 1'($urandom_range(0, 1));
         alu_rd         = 5'($urandom);
         alu_data       = {$urandom, $urandom};
         ld_issue_valid = ($urandom_range(0, 9) < 4);
         ld_issue_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if (!reset && outq.size() > 0 && $urandom_range(0, 9) < 4)
            setResp(5'(outq.pop_front()), {$urandom, $urandom},
                    3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)));
         else
            ld_resp_valid = 1'b0;
         byp_addr1 = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom);
         byp_addr2 = 5'($urandom);
         applyStimulus();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
